// File: rtl/bellek_port_yanitlayici_pkg.sv
// Shared bus widths and logic levels for the memory port responder slice.
// Optional wait-state feature is selected by VYB_YANIT_GECIKME_EN (see top).
`ifndef SABITLER_VH
`define SABITLER_VH
`define ADRES_BIT 32
`define VERI_BIT  32
`define VERI_BYTE 4
`define HIGH      1'b1
`define LOW       1'b0
`endif

package bellek_port_yanitlayici_pkg;
  localparam int   ADRES_W = `ADRES_BIT;
  localparam int   VERI_W  = `VERI_BIT;
  localparam int   BYTE_N  = `VERI_BYTE;
  localparam logic YUKSEK  = `HIGH;
  localparam logic DUSUK   = `LOW;
endpackage

// File: rtl/bellek_port_yanitlayici_if.sv
// Request/response bundle between a requester and the memory port responder.
interface bellek_port_yanitlayici_if;
  import bellek_port_yanitlayici_pkg::*;

  logic [ADRES_W-1:0] port_istek_adres_i;
  logic               port_istek_gecerli_i;
  logic               port_istek_yaz_i;
  logic [VERI_W-1:0]  port_istek_veri_i;
  logic [BYTE_N-1:0]  port_istek_maske_i;
  logic               port_istek_hazir_o;
  logic [VERI_W-1:0]  port_veri_o;
  logic               port_veri_gecerli_o;
  logic               port_veri_hazir_i;

  modport slave (
    input  port_istek_adres_i, port_istek_gecerli_i, port_istek_yaz_i,
    input  port_istek_veri_i, port_istek_maske_i, port_veri_hazir_i,
    output port_istek_hazir_o, port_veri_o, port_veri_gecerli_o
  );

  modport master (
    output port_istek_adres_i, port_istek_gecerli_i, port_istek_yaz_i,
    output port_istek_veri_i, port_istek_maske_i, port_veri_hazir_i,
    input  port_istek_hazir_o, port_veri_o, port_veri_gecerli_o
  );
endinterface

// File: rtl/bellek_port_yanitlayici_bellek_dizisi.sv
// Single-port word array: byte-masked synchronous write, combinational read
// so a read right after a write to the same word sees the new data.
module bellek_dizisi
  import bellek_port_yanitlayici_pkg::*;
#(
  parameter int SATIR = 1024,
  localparam int IDX_W = $clog2(SATIR)
) (
  input  logic              clk_i,
  input  logic              yaz_i,
  input  logic [IDX_W-1:0]  satir_i,
  input  logic [VERI_W-1:0] veri_i,
  input  logic [BYTE_N-1:0] maske_i,
  output logic [VERI_W-1:0] veri_o
);
  // Contents deliberately survive reset.
  logic [BYTE_N-1:0][7:0] dizi_q [SATIR];

  always_ff @(posedge clk_i) begin
    if (yaz_i) begin
      for (int b = 0; b < BYTE_N; b++) begin
        if (maske_i[b]) dizi_q[satir_i][b] <= veri_i[b*8 +: 8];
      end
    end
  end

  assign veri_o = dizi_q[satir_i];
endmodule

// File: rtl/bellek_port_yanitlayici.sv
// Memory port responder: one request at a time, reads answered via a held
// response register; VYB_YANIT_GECIKME_EN adds GECIKME wait states per request.
module bellek_port_yanitlayici
  import bellek_port_yanitlayici_pkg::*;
#(
  parameter int BELLEK_SATIR = 1024,
  parameter int GECIKME      = 2
) (
  input logic clk_i,
  input logic rstn_i,
  bellek_port_yanitlayici_if.slave port
);
  localparam int IDX_W = $clog2(BELLEK_SATIR);

  typedef enum logic [1:0] {
    DRM_HAZIR   = 2'd0,
    DRM_GECIKME = 2'd1,
    DRM_YANIT   = 2'd2
  } durum_e;

  durum_e            durum_q, durum_d;
  logic [VERI_W-1:0] yanit_q, yanit_d;
  logic [VERI_W-1:0] oku_veri;
  logic [IDX_W-1:0]  satir;
  logic              hazir, kabul, gecerli;
  logic              gecikme_bitti, bekleyen_yaz;
  logic              unused_adres;

  assign hazir   = (durum_q == DRM_HAZIR);
  assign gecerli = (durum_q == DRM_YANIT);
  assign kabul   = port.port_istek_gecerli_i & hazir;
  assign satir   = port.port_istek_adres_i[IDX_W+1:2];
  // Upper address bits are dropped on purpose so addresses wrap.
  assign unused_adres = ^{port.port_istek_adres_i[ADRES_W-1:IDX_W+2],
                          port.port_istek_adres_i[1:0]};

  assign port.port_istek_hazir_o  = hazir;
  assign port.port_veri_gecerli_o = gecerli;
  assign port.port_veri_o         = gecerli ? yanit_q : '0;

  bellek_dizisi #(.SATIR(BELLEK_SATIR)) u_dizi (
    .clk_i   (clk_i),
    .yaz_i   (kabul & port.port_istek_yaz_i),
    .satir_i (satir),
    .veri_i  (port.port_istek_veri_i),
    .maske_i (port.port_istek_maske_i),
    .veri_o  (oku_veri)
  );

`ifdef VYB_YANIT_GECIKME_EN
  localparam bit GEC_VAR = (GECIKME > 0);
  if (GECIKME > 0) begin : g_sayac
    localparam int SAY_W = $clog2(GECIKME + 1);
    logic [SAY_W-1:0] say_q, say_d;
    logic             yaz_q, yaz_d;

    always_comb begin
      say_d = say_q;
      yaz_d = yaz_q;
      if (kabul) begin
        say_d = SAY_W'(GECIKME);
        yaz_d = port.port_istek_yaz_i;
      end else if (durum_q == DRM_GECIKME && say_q != '0) begin
        say_d = say_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        say_q <= '0;
        yaz_q <= DUSUK;
      end else begin
        say_q <= say_d;
        yaz_q <= yaz_d;
      end
    end

    // Last wait cycle: leave GECIKME on this edge.
    assign gecikme_bitti = (say_q == SAY_W'(1));
    assign bekleyen_yaz  = yaz_q;
  end else begin : g_sayac_yok
    assign gecikme_bitti = YUKSEK;
    assign bekleyen_yaz  = DUSUK;
  end
`else
  localparam bit GEC_VAR = 1'b0;
  assign gecikme_bitti = YUKSEK;
  assign bekleyen_yaz  = DUSUK;
`endif

  always_comb begin
    durum_d = durum_q;
    yanit_d = yanit_q;
    case (durum_q)
      DRM_HAZIR: begin
        if (kabul) begin
          if (!port.port_istek_yaz_i) yanit_d = oku_veri;
          if (GEC_VAR)                     durum_d = DRM_GECIKME;
          else if (!port.port_istek_yaz_i) durum_d = DRM_YANIT;
        end
      end
      DRM_GECIKME: begin
        if (gecikme_bitti) durum_d = bekleyen_yaz ? DRM_HAZIR : DRM_YANIT;
      end
      DRM_YANIT: begin
        if (port.port_veri_hazir_i) durum_d = DRM_HAZIR;
      end
      default: durum_d = DRM_HAZIR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q <= DRM_HAZIR;
      yanit_q <= '0;
    end else begin
      durum_q <= durum_d;
      yanit_q <= yanit_d;
    end
  end
endmodule
